// File: rtl/sha3_scan_arbiter.sv
// sha3_scan_arbiter: round-robin sharing of one iterative SHA3 scanner among N_REQ requesters, one job at a time.
// Optional watchdog abort compiled in with `define SHA3_SCAN_ARB_WATCHDOG_EN.
module sha3_scan_arbiter #(
  parameter int N_REQ = 4,
  parameter int JOB_W = 64,
  parameter int WDOG_CYCLES = 4096,
  localparam int OW = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*JOB_W-1:0] req_job,
  output logic [N_REQ-1:0]   req_ready,
  output logic               scan_valid,
  output logic [JOB_W-1:0]   scan_job,
  input  logic               scan_ready,
  input  logic               res_valid,
  input  logic               res_found,
  input  logic [31:0]        res_nonce,
  input  logic               res_last,
  output logic               out_valid,
  output logic [OW-1:0]      out_owner,
  output logic               out_found,
  output logic               out_last,
  output logic [31:0]        out_nonce,
  output logic               busy,
  output logic               abort,
  output logic [7:0]         drop_cnt
);
  typedef enum logic [1:0] {IDLE, DISPATCH, WAIT} state_t;
  state_t state;
  logic [OW-1:0] rr_ptr, owner, gnt, idx;
  logic gnt_ok, wd_fire;
  logic [JOB_W-1:0] job;
  logic [JOB_W-1:0] jobs [N_REQ];

  if (N_REQ < 2 || N_REQ > 16 || WDOG_CYCLES < 2) begin : g_bad_cfg
    $error("sha3_scan_arbiter: parameter out of range");
  end

  for (genvar i = 0; i < N_REQ; i++) begin : g_jobs
    assign jobs[i] = req_job[i*JOB_W +: JOB_W];
  end

  function automatic logic [OW-1:0] inc(input logic [OW-1:0] v);
    return (32'(v) == N_REQ - 1) ? '0 : v + 1'b1;
  endfunction

  // Highest offset first so the nearest valid requester above rr_ptr wins.
  always_comb begin
    gnt = '0;
    gnt_ok = 1'b0;
    idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = OW'((int'(rr_ptr) + k) % N_REQ);
      if (req_valid[idx]) begin
        gnt = idx;
        gnt_ok = 1'b1;
      end
    end
  end

  assign req_ready  = (state == IDLE && gnt_ok && rst_n) ? N_REQ'(1) << gnt : '0;
  assign scan_valid = state == DISPATCH;
  assign scan_job   = job;
  assign busy       = state != IDLE;

`ifdef SHA3_SCAN_ARB_WATCHDOG_EN
  localparam int CW = $clog2(WDOG_CYCLES);
  logic [CW-1:0] wdog;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog  <= '0;
      abort <= 1'b0;
    end else begin
      wdog  <= (state != WAIT || res_valid) ? '0 : wdog + 1'b1;
      abort <= state == WAIT && !res_valid && !abort && wdog == CW'(WDOG_CYCLES - 2);
    end
  end
  assign wd_fire = abort;
`else
  assign abort   = 1'b0;
  assign wd_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      job       <= '0;
      drop_cnt  <= '0;
      out_valid <= 1'b0;
      out_owner <= '0;
      out_found <= 1'b0;
      out_last  <= 1'b0;
      out_nonce <= '0;
    end else begin
      out_valid <= 1'b0;
      if (res_valid && state != WAIT && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 1'b1;
      case (state)
        IDLE: if (gnt_ok) begin
          state <= DISPATCH;
          owner <= gnt;
          job   <= jobs[gnt];
        end
        DISPATCH: if (scan_ready) state <= WAIT;
        WAIT: if (wd_fire) begin
          out_valid <= 1'b1;
          out_owner <= owner;
          out_found <= 1'b0;
          out_last  <= 1'b1;
          out_nonce <= '0;
          state     <= IDLE;
          rr_ptr    <= inc(owner);
        end else if (res_valid) begin
          out_valid <= 1'b1;
          out_owner <= owner;
          out_found <= res_found;
          out_last  <= res_last;
          out_nonce <= res_nonce;
          if (res_last) begin
            state  <= IDLE;
            rr_ptr <= inc(owner);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sha3_scan_arbiter.sv
// tb_sha3_scan_arbiter: scenario tasks plus a result-beat scoreboard for sha3_scan_arbiter (N_REQ=4, WDOG_CYCLES=16).
module tb_sha3_scan_arbiter;
  localparam int N = 4, JW = 64, WD = 16;
  typedef logic [35:0] beat_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N*JW-1:0] req_job = '0;
  logic scan_valid, scan_ready = 1'b0;
  logic [JW-1:0] scan_job;
  logic res_valid = 1'b0, res_found = 1'b0, res_last = 1'b0;
  logic [31:0] res_nonce = '0;
  logic out_valid, out_found, out_last, busy, abort;
  logic [1:0] out_owner;
  logic [31:0] out_nonce;
  logic [7:0] drop_cnt;
  beat_t sb[$];
  int vec = 0, errs = 0;

  sha3_scan_arbiter #(.N_REQ(N), .JOB_W(JW), .WDOG_CYCLES(WD)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_job(req_job), .req_ready(req_ready),
    .scan_valid(scan_valid), .scan_job(scan_job), .scan_ready(scan_ready),
    .res_valid(res_valid), .res_found(res_found), .res_nonce(res_nonce), .res_last(res_last),
    .out_valid(out_valid), .out_owner(out_owner), .out_found(out_found), .out_last(out_last),
    .out_nonce(out_nonce), .busy(busy), .abort(abort), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  always @(negedge clk) begin
    beat_t e;
    if (rst_n && out_valid) begin
      vec++;
      if (sb.size() == 0) begin
        errs++;
        $display("FAIL unexpected_beat: got owner=%0d found=%0b last=%0b nonce=%h, expected none",
                 out_owner, out_found, out_last, out_nonce);
      end else begin
        e = sb.pop_front();
        if ({out_owner, out_found, out_last, out_nonce} !== e) begin
          errs++;
          $display("FAIL beat: got %h expected %h", {out_owner, out_found, out_last, out_nonce}, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req_valid = '1;
    repeat (3) @(posedge clk);
    #1;
    vec++;
    if ({req_ready, scan_valid, scan_job, out_valid, out_owner, out_found, out_last, out_nonce, busy, abort, drop_cnt} !== '0) begin
      errs++;
      $display("FAIL reset_outputs: req_ready=%b scan_valid=%b busy=%b drop=%0d out_valid=%b", req_ready, scan_valid, busy, drop_cnt, out_valid);
    end
    req_valid = '0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_tagging();
    logic [63:0] j = 64'h0123_4567_89ab_cdef;
    req_job[3*JW +: JW] = j;
    req_valid = 4'b1000;
    #1;
    vec++;
    if (req_ready !== 4'b1000) begin errs++; $display("FAIL tag_grant: got %b expected 1000", req_ready); end
    step();
    req_valid = '0;
    #1;
    vec++;
    if (scan_valid !== 1'b1 || scan_job !== j) begin errs++; $display("FAIL tag_dispatch: valid=%b job=%h expected 1 %h", scan_valid, scan_job, j); end
    scan_ready = 1'b1;
    step();
    scan_ready = 1'b0;
    res_valid = 1'b1; res_found = 1'b1; res_nonce = 32'hDEADBEEF; res_last = 1'b0;
    sb.push_back({2'd3, 1'b1, 1'b0, 32'hDEADBEEF});
    step();
    vec++;
    if (out_valid !== 1'b1 || out_owner !== 2'd3 || out_nonce !== 32'hDEADBEEF)
      begin errs++; $display("FAIL tag_latency: valid=%b owner=%0d nonce=%h expected 1 3 deadbeef", out_valid, out_owner, out_nonce); end
    res_found = 1'b0; res_nonce = '0; res_last = 1'b1;
    sb.push_back({2'd3, 1'b0, 1'b1, 32'h0});
    step();
    res_valid = 1'b0; res_last = 1'b0;
    #1;
    vec++;
    if (busy !== 1'b0 || out_last !== 1'b1) begin errs++; $display("FAIL tag_end: busy=%b out_last=%b expected 0 1", busy, out_last); end
  endtask

  task automatic test_round_robin();
    int g;
    for (int i = 0; i < N; i++) req_job[i*JW +: JW] = 64'h1000 + 64'(i);
    req_valid = '1;
    #1;
    for (int n = 0; n < 5; n++) begin
      g = n % N;
      vec++;
      if (req_ready !== 4'(1 << g)) begin errs++; $display("FAIL rr_grant%0d: got %b expected %b", n, req_ready, 4'(1 << g)); end
      step();
      #1;
      vec++;
      if (scan_valid !== 1'b1 || scan_job !== 64'h1000 + 64'(g))
        begin errs++; $display("FAIL rr_dispatch%0d: valid=%b job=%h expected 1 %h", n, scan_valid, scan_job, 64'h1000 + 64'(g)); end
      scan_ready = 1'b1;
      step();
      scan_ready = 1'b0;
      res_valid = 1'b1; res_last = 1'b1; res_found = 1'b0; res_nonce = 32'(n);
      sb.push_back({2'(g), 1'b0, 1'b1, 32'(n)});
      step();
      res_valid = 1'b0; res_last = 1'b0;
      #1;
    end
    req_valid = '0;
    step();
  endtask

  task automatic test_stall();
    logic [63:0] j = 64'hCAFE_F00D_1234_5678;
    req_job[JW +: JW] = j;
    req_valid = 4'b0110;
    #1;
    vec++;
    if (req_ready !== 4'b0010) begin errs++; $display("FAIL stall_grant: got %b expected 0010", req_ready); end
    step();
    #1;
    for (int c = 0; c < 10; c++) begin
      vec++;
      if (scan_valid !== 1'b1 || scan_job !== j || req_ready !== 4'b0000)
        begin errs++; $display("FAIL stall_c%0d: valid=%b job=%h ready=%b expected 1 %h 0000", c, scan_valid, scan_job, req_ready, j); end
      step();
      #1;
    end
    scan_ready = 1'b1;
    step();
    scan_ready = 1'b0;
    req_valid = '0;
    res_valid = 1'b1; res_last = 1'b1; res_nonce = '0;
    sb.push_back({2'd1, 1'b0, 1'b1, 32'h0});
    step();
    res_valid = 1'b0; res_last = 1'b0;
    step();
  endtask

  task automatic test_drop();
    res_valid = 1'b1; res_found = 1'b1; res_nonce = 32'h5;
    for (int i = 0; i < 300; i++) begin
      if (i == 100) begin
        vec++;
        if (drop_cnt !== 8'd100) begin errs++; $display("FAIL drop_mid: got %0d expected 100", drop_cnt); end
      end
      step();
    end
    res_valid = 1'b0; res_found = 1'b0; res_nonce = '0;
    #1;
    vec++;
    if (drop_cnt !== 8'd255 || busy !== 1'b0 || out_valid !== 1'b0)
      begin errs++; $display("FAIL drop_sat: drop=%0d busy=%b out_valid=%b expected 255 0 0", drop_cnt, busy, out_valid); end
    step();
  endtask

  task automatic test_reset_mid_job();
    req_job[0 +: JW] = 64'h77;
    req_valid = 4'b0001;
    #1;
    vec++;
    if (req_ready !== 4'b0001) begin errs++; $display("FAIL rst_pre_grant: got %b expected 0001", req_ready); end
    step();
    req_valid = '0;
    scan_ready = 1'b1;
    step();
    scan_ready = 1'b0;
    #1;
    vec++;
    if (busy !== 1'b1) begin errs++; $display("FAIL rst_busy_wait: got %b expected 1", busy); end
    rst_n = 1'b0;
    #1;
    vec++;
    if ({req_ready, scan_valid, scan_job, out_valid, out_owner, out_found, out_last, out_nonce, busy, abort, drop_cnt} !== '0)
      begin errs++; $display("FAIL rst_mid_outputs: busy=%b drop=%0d scan_valid=%b", busy, drop_cnt, scan_valid); end
    step();
    step();
    rst_n = 1'b1;
    req_job[2*JW +: JW] = 64'h22;
    req_valid = 4'b0100;
    #1;
    vec++;
    if (req_ready !== 4'b0100) begin errs++; $display("FAIL rst_post_grant: got %b expected 0100", req_ready); end
    step();
    req_valid = '0;
    scan_ready = 1'b1;
    step();
    scan_ready = 1'b0;
    res_valid = 1'b1; res_last = 1'b1; res_nonce = 32'h22;
    sb.push_back({2'd2, 1'b0, 1'b1, 32'h22});
    step();
    res_valid = 1'b0; res_last = 1'b0; res_nonce = '0;
    step();
  endtask

  task automatic test_watchdog();
    req_job[3*JW +: JW] = 64'h33;
    req_job[0 +: JW] = 64'h44;
    req_valid = 4'b1001;
    #1;
    vec++;
    if (req_ready !== 4'b1000) begin errs++; $display("FAIL wd_grant: got %b expected 1000", req_ready); end
    step();
    req_valid = '0;
    scan_ready = 1'b1;
    step();
    scan_ready = 1'b0;
    #1;
`ifdef SHA3_SCAN_ARB_WATCHDOG_EN
    for (int k = 0; k <= 15; k++) begin
      vec++;
      if (abort !== (k == 15)) begin errs++; $display("FAIL wd_abort_k%0d: got %b expected %b", k, abort, k == 15); end
      if (k < 15) begin step(); #1; end
    end
    sb.push_back({2'd3, 1'b0, 1'b1, 32'h0});
    req_valid = 4'b1001;
    step();
    #1;
    vec++;
    if (abort !== 1'b0 || out_valid !== 1'b1 || out_last !== 1'b1)
      begin errs++; $display("FAIL wd_synth: abort=%b out_valid=%b out_last=%b expected 0 1 1", abort, out_valid, out_last); end
`else
    for (int k = 0; k < 40; k++) begin
      vec++;
      if (abort !== 1'b0 || busy !== 1'b1) begin errs++; $display("FAIL nowd_wait_k%0d: abort=%b busy=%b expected 0 1", k, abort, busy); end
      step();
      #1;
    end
    res_valid = 1'b1; res_last = 1'b1; res_nonce = 32'h33;
    sb.push_back({2'd3, 1'b0, 1'b1, 32'h33});
    req_valid = 4'b1001;
    step();
    res_valid = 1'b0; res_last = 1'b0; res_nonce = '0;
    #1;
`endif
    vec++;
    if (req_ready !== 4'b0001) begin errs++; $display("FAIL wd_next_grant: got %b expected 0001", req_ready); end
    req_valid = '0;
    repeat (3) step();
  endtask

  initial begin
    test_reset();
    test_tagging();
    test_round_robin();
    test_stall();
    test_drop();
    test_reset_mid_job();
    test_watchdog();
    vec++;
    if (sb.size() != 0) begin errs++; $display("FAIL scoreboard_drain: %0d beats never seen, expected 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/sha3_scan_arbiter.md
# sha3_scan_arbiter

Shares one iterative SHA3 scanner (packed-by-6 hasher plus its control FSM) among `N_REQ` independent requesters. Jobs are granted round-robin, one job at a time, since the iterative hasher cannot interleave scans. Result beats are tagged with the owning requester's index. The block sits between the job sources (host/mailbox side) and the scanner's request/result buses.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..16.
- `JOB_W`, 64: width of an opaque job descriptor (start nonce, count, target), passed through unmodified.
- `WDOG_CYCLES`, 4096: watchdog limit in cycles, at least 2. Used only when the watchdog is compiled in.

Ports (`OW` = `$clog2(N_REQ)`):
- `clk`  in  1  sole clock; all logic on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  N_REQ  requester i has a job pending.
- `req_job`  in  N_REQ*JOB_W  job of requester i at bits [i*JOB_W +: JOB_W].
- `req_ready`  out  N_REQ  one-hot pulse; job i accepted this cycle.
- `scan_valid`  out  1  job offered to scanner.
- `scan_job`  out  JOB_W  job descriptor to scanner.
- `scan_ready`  in  1  scanner accepts a job (scanner ready).
- `res_valid`  in  1  scanner result beat.
- `res_found`  in  1  beat carries a hit.
- `res_nonce`  in  32  nonce of the hit.
- `res_last`  in  1  final beat of the current job.
- `out_valid`  out  1  tagged result beat.
- `out_owner`  out  OW  requester index owning the beat.
- `out_found`, `out_last`  out  1 each  forwarded flags.
- `out_nonce`  out  32  forwarded nonce.
- `busy`  out  1  a job is granted and not yet finished.
- `abort`  out  1  watchdog fired (1-cycle pulse).
- `drop_cnt`  out  8  saturating count of result beats received while not in WAIT.

## Operation
- State machine: IDLE, DISPATCH, WAIT.
- **IDLE**
  - If `req_valid` is nonzero, grant the first set bit scanning upward from `rr_ptr`, wrapping modulo N_REQ.
  - In the same cycle, drive `req_ready[g]`=1, latch `req_job[g]` and owner `g`, and go to DISPATCH.
  - If `req_valid` is zero, stay in IDLE.
- **DISPATCH**
  - `scan_valid`=1 and `scan_job` = latched job, both held stable until `scan_ready`=1.
  - On `scan_valid && scan_ready`, go to WAIT.
- **WAIT**
  - Every `res_valid` beat is registered and re-emitted next cycle with `out_owner` = latched owner.
  - There is no backpressure on the result path.
  - On `res_valid && res_last`, set `rr_ptr` = (owner+1) mod N_REQ and go to IDLE.
- `busy` = state != IDLE.
- A `res_valid` beat outside WAIT is discarded and increments `drop_cnt`, which saturates at 255.
- A requester that drops `req_valid` before being granted is skipped without side effects.
- Jobs are never queued; the latched job is the only storage.

## Timing
- Reset value of every output is 0, and state goes to IDLE. `rr_ptr`, the owner and the latched job are also cleared. `rst_n` may assert in any state; in-flight work is lost. The scanner must be reset in the same domain.
- Grant latency: `req_valid` seen in IDLE gives `req_ready` in the same cycle and `scan_valid` in the next cycle.
- Result latency: `out_*` is valid exactly one cycle after the matching `res_*` beat.
- Back-to-back jobs: the `res_last` beat is at cycle t. The state is IDLE at t+1, a grant is possible at t+1, and `scan_valid` is asserted at t+2.
- `res_last` arriving in the same cycle as the DISPATCH handshake is counted as a drop; the scanner never produces this.
- Round-robin fairness: with all requesters valid, each is granted once per N_REQ jobs.

## Configuration
- Macro: `SHA3_SCAN_ARB_WATCHDOG_EN`.
- **Defined:**
  - A counter clears on entry to WAIT and on every `res_valid`, and increments otherwise while in WAIT.
  - When it reaches WDOG_CYCLES-1, the block pulses `abort` for one cycle.
  - In the next cycle it emits a synthetic beat with `out_valid`=1, `out_last`=1, `out_found`=0, `out_nonce`=0 and the current owner.
  - It then advances `rr_ptr` and goes to IDLE.
- **Undefined:** no counter, `abort` is tied to 0, and WAIT lasts until `res_last`.

## Test plan
- **Reset mid-job:** `rst_n` low during WAIT -> all outputs 0 and `busy`=0 on the same edge. After release, requester 2 valid -> `req_ready`=4'b0100.
- **Round-robin:** N_REQ=4, all valid continuously, each job ends with one `res_last` beat -> grant order 0,1,2,3,0 with no repeats.
- **Tagging:** requester 3 granted; scanner sends hit nonce 0xDEADBEEF then `res_last` -> `out_owner`=3, `out_found`=1, `out_nonce`=0xDEADBEEF one cycle later, then `out_last`=1.
- **Stall:** `scan_ready` held low 10 cycles -> `scan_valid` and `scan_job` stable for all 10 cycles, and no second `req_ready` pulse.
- **Drop counter:** 300 stray `res_valid` beats in IDLE -> `drop_cnt`=255 and no `out_valid`.
- **Watchdog:** with `SHA3_SCAN_ARB_WATCHDOG_EN` and WDOG_CYCLES=16, no results after dispatch -> `abort` pulses 15 cycles after WAIT entry, then a synthetic `out_last` beat, then the next requester is granted.
